jtkcpu_intctrl: RTL and testbench

JTKCPU_INTCTRL -- requirements
Module: jtkcpu_intctrl

---
 rtl/jtkcpu_pkg.sv | 30 +++
 rtl/jtkcpu_nmi_edge.sv | 46 ++++
 rtl/jtkcpu_intctrl.sv | 90 +++++++++
 tb/tb_jtkcpu_intctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_pkg.sv
// Shared vector codes, FSM state encodings and source arbitration for the
// KCPU interrupt controller.
package jtkcpu_pkg;

    localparam logic [1:0] ST_RSTV = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [1:0] ST_VECT = 2'd3;

    localparam logic [2:0] VEC_NONE = 3'd0;
    localparam logic [2:0] VEC_IRQ  = 3'd1;
    localparam logic [2:0] VEC_FIRQ = 3'd2;
    localparam logic [2:0] VEC_NMI  = 3'd3;
    localparam logic [2:0] VEC_RST  = 3'd4;

    // Fixed priority: NMI over FIRQ over IRQ
    function automatic logic [2:0] src_win(
        input logic nmi,
        input logic firq,
        input logic irq
    );
        logic [2:0] w;
        w = VEC_NONE;
        if (nmi)       w = VEC_NMI;
        else if (firq) w = VEC_FIRQ;
        else if (irq)  w = VEC_IRQ;
        return w;
    endfunction

endpackage

// File: rtl/jtkcpu_nmi_edge.sv
// NMI falling-edge sampler, latch and arming logic.
// Define JTKCPU_NMI_ARM_EN to keep NMI disarmed until the first nmi_arm pulse.
module jtkcpu_nmi_edge (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic nmi_n,
    input  logic nmi_arm,
    input  logic clr,
    output logic nmi_lat
);

    logic prev;
    logic armed;
    logic edge_seen;

`ifdef JTKCPU_NMI_ARM_EN
    always_ff @(posedge clk) begin
        if (rst)
            armed <= 1'b0;
        else if (cen && nmi_arm)
            armed <= 1'b1;
    end
`else
    logic unused_arm;
    assign unused_arm = nmi_arm;
    assign armed      = 1'b1;
`endif

    assign edge_seen = armed && prev && !nmi_n;

    // A fresh edge wins over a clear landing in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= 1'b1;
            nmi_lat <= 1'b0;
        end else if (cen) begin
            prev <= nmi_n;
            if (edge_seen)
                nmi_lat <= 1'b1;
            else if (clr)
                nmi_lat <= 1'b0;
        end
    end

endmodule

// File: rtl/jtkcpu_intctrl.sv
// KCPU interrupt controller: arbitrates NMI/FIRQ/IRQ and hands the vector
// code to the memory controller. Optional macro: JTKCPU_NMI_ARM_EN.
module jtkcpu_intctrl
    import jtkcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       nmi_n,
    input  logic       firq_n,
    input  logic       irq_n,
    input  logic       cc_f,
    input  logic       cc_i,
    input  logic       nmi_arm,
    input  logic       take,
    input  logic       vec_done,
    output logic       int_req,
    output logic [2:0] vector,
    output logic       fast
);

    logic [1:0] state;
    logic       nmi_lat;
    logic       nmi_clr;
    logic       firq_act;
    logic       irq_act;
    logic       pending;
    logic [2:0] win;

    assign firq_act = !firq_n && !cc_f;
    assign irq_act  = !irq_n && !cc_i;
    assign win      = src_win(nmi_lat, firq_act, irq_act);
    assign pending  = win != VEC_NONE;
    assign fast     = vector == VEC_FIRQ;

    // NMI wins whenever the latch is set, so taking with nmi_lat clears it
    assign nmi_clr = cen && take && nmi_lat && (state == ST_PEND);

    jtkcpu_nmi_edge u_nmi (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .nmi_n   (nmi_n),
        .nmi_arm (nmi_arm),
        .clr     (nmi_clr),
        .nmi_lat (nmi_lat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RSTV;
            vector  <= VEC_RST;
            int_req <= 1'b0;
        end else if (cen) begin
            case (state)
                ST_RSTV: begin
                    int_req <= 1'b0;
                    if (vec_done) begin
                        state  <= ST_IDLE;
                        vector <= VEC_NONE;
                    end
                end
                ST_IDLE: begin
                    if (pending) begin
                        state   <= ST_PEND;
                        int_req <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!pending) begin
                        state   <= ST_IDLE;
                        int_req <= 1'b0;
                    end else if (take) begin
                        state   <= ST_VECT;
                        vector  <= win;
                        int_req <= 1'b0;
                    end
                end
                default: begin
                    int_req <= 1'b0;
                    if (vec_done) begin
                        state  <= ST_IDLE;
                        vector <= VEC_NONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_intctrl.sv
// Scoreboard bench for jtkcpu_intctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_jtkcpu_intctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       nmi_n = 1'b1;
    logic       firq_n = 1'b1;
    logic       irq_n = 1'b1;
    logic       cc_f = 1'b0;
    logic       cc_i = 1'b0;
    logic       nmi_arm = 1'b0;
    logic       take = 1'b0;
    logic       vec_done = 1'b0;
    logic       int_req;
    logic [2:0] vector;
    logic       fast;

    typedef struct {
        int         cyc;
        logic       req;
        logic [2:0] vec;
        logic       fst;
        string      name;
    } exp_t;

    exp_t q[$];
    int   ncyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    jtkcpu_intctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .nmi_n    (nmi_n),
        .firq_n   (firq_n),
        .irq_n    (irq_n),
        .cc_f     (cc_f),
        .cc_i     (cc_i),
        .nmi_arm  (nmi_arm),
        .take     (take),
        .vec_done (vec_done),
        .int_req  (int_req),
        .vector   (vector),
        .fast     (fast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= ncyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (int_req !== e.req || vector !== e.vec || fast !== e.fst) begin
                n_bad++;
                $display("FAIL %s: got req=%b vec=%0d fast=%b, want req=%b vec=%0d fast=%b",
                         e.name, int_req, vector, fast, e.req, e.vec, e.fst);
            end
        end
    end

    // Inputs are already driven; expectation is for after the next edge
    task automatic tick(input logic er, input logic [2:0] ev, input string nm);
        exp_t e;
        e.cyc  = ncyc + 1;
        e.req  = er;
        e.vec  = ev;
        e.fst  = (ev == 3'd2);
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        rst = 1'b1;
        tick(0, 4, "rst_1");
        tick(0, 4, "rst_2");
        rst = 1'b0;
        tick(0, 4, "rstv_hold");
        vec_done = 1'b1;
        tick(0, 0, "rstv_exit");
        vec_done = 1'b0;
        tick(0, 0, "idle");

        take = 1'b1;
        tick(0, 0, "take_in_idle");
        take = 1'b0;
        vec_done = 1'b1;
        tick(0, 0, "vdone_in_idle");
        vec_done = 1'b0;

        irq_n = 1'b0;
        tick(1, 0, "irq_req");
        tick(1, 0, "irq_hold");
        take = 1'b1;
        tick(0, 1, "irq_take");
        take = 1'b0;
        irq_n = 1'b1;
        tick(0, 1, "irq_vect");
        vec_done = 1'b1;
        tick(0, 0, "irq_done");
        vec_done = 1'b0;
        tick(0, 0, "irq_idle");

        firq_n = 1'b0;
        irq_n = 1'b0;
        tick(1, 0, "firq_req");
        take = 1'b1;
        tick(0, 2, "firq_take");
        take = 1'b0;
        firq_n = 1'b1;
        irq_n = 1'b1;
        tick(0, 2, "firq_vect");
        vec_done = 1'b1;
        tick(0, 0, "firq_done");
        vec_done = 1'b0;

        cc_f = 1'b1;
        firq_n = 1'b0;
        irq_n = 1'b0;
        tick(1, 0, "fmask_req");
        take = 1'b1;
        tick(0, 1, "fmask_take");
        take = 1'b0;
        firq_n = 1'b1;
        irq_n = 1'b1;
        vec_done = 1'b1;
        tick(0, 0, "fmask_done");
        vec_done = 1'b0;
        cc_f = 1'b0;

        irq_n = 1'b0;
        tick(1, 0, "vanish_req");
        irq_n = 1'b1;
        tick(0, 0, "vanish_drop");
        tick(0, 0, "vanish_idle");

        irq_n = 1'b0;
        tick(1, 0, "mask_req");
        cc_i = 1'b1;
        tick(0, 0, "mask_drop");
        irq_n = 1'b1;
        cc_i = 1'b0;
        tick(0, 0, "mask_idle");

`ifdef JTKCPU_NMI_ARM_EN
        nmi_n = 1'b0;
        tick(0, 0, "nmi_unarmed_edge");
        tick(0, 0, "nmi_unarmed_none");
        nmi_n = 1'b1;
        tick(0, 0, "nmi_unarmed_rel");
`endif
        nmi_arm = 1'b1;
        tick(0, 0, "nmi_arm");
        nmi_arm = 1'b0;

        nmi_n = 1'b0;
        tick(0, 0, "nmi_edge");
        tick(1, 0, "nmi_req");
        take = 1'b1;
        tick(0, 3, "nmi_take");
        take = 1'b0;
        nmi_n = 1'b1;
        tick(0, 3, "nmi_vect");
        nmi_n = 1'b0;
        tick(0, 3, "nmi2_in_vect");
        vec_done = 1'b1;
        tick(0, 0, "nmi_done");
        vec_done = 1'b0;
        tick(1, 0, "nmi2_req");
        take = 1'b1;
        tick(0, 3, "nmi2_take");
        take = 1'b0;
        nmi_n = 1'b1;
        vec_done = 1'b1;
        tick(0, 0, "nmi2_done");
        vec_done = 1'b0;
        tick(0, 0, "nmi_lat_clear");

        irq_n = 1'b0;
        tick(1, 0, "pre_irq_req");
        nmi_n = 1'b0;
        tick(1, 0, "pre_nmi_edge");
        take = 1'b1;
        tick(0, 3, "pre_take_nmi");
        take = 1'b0;
        irq_n = 1'b1;
        nmi_n = 1'b1;
        tick(0, 3, "pre_vect");
        vec_done = 1'b1;
        tick(0, 0, "pre_done");
        vec_done = 1'b0;
        tick(0, 0, "pre_idle");

        cen = 1'b0;
        nmi_n = 1'b0;
        take = 1'b1;
        irq_n = 1'b0;
        tick(0, 0, "cen0_hold_1");
        tick(0, 0, "cen0_hold_2");
        cen = 1'b1;
        take = 1'b0;
        irq_n = 1'b1;
        tick(0, 0, "cen1_edge");
        tick(1, 0, "cen1_req");
        take = 1'b1;
        tick(0, 3, "cen1_take");
        take = 1'b0;
        nmi_n = 1'b1;
        vec_done = 1'b1;
        tick(0, 0, "cen1_done");
        vec_done = 1'b0;

        irq_n = 1'b0;
        tick(1, 0, "rpend_req");
        rst = 1'b1;
        irq_n = 1'b1;
        tick(0, 4, "rpend_rst");
        rst = 1'b0;
        tick(0, 4, "rpend_rstv");
        vec_done = 1'b1;
        tick(0, 0, "rpend_exit");
        vec_done = 1'b0;
        tick(0, 0, "rpend_idle");

        nmi_arm = 1'b1;
        tick(0, 0, "rlat_arm");
        nmi_arm = 1'b0;
        nmi_n = 1'b0;
        tick(0, 0, "rlat_edge");
        rst = 1'b1;
        nmi_n = 1'b1;
        tick(0, 4, "rlat_rst");
        rst = 1'b0;
        vec_done = 1'b1;
        tick(0, 0, "rlat_exit");
        vec_done = 1'b0;
        tick(0, 0, "rlat_none_1");
        tick(0, 0, "rlat_none_2");

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
    end

    initial begin
        fork
            wait (stim_done);
            #100000;
        join_any
        disable fork;
        if (!stim_done) begin
            n_bad++;
            $display("FAIL timeout: got stim_done=0, want 1");
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_bad++;
            $display("FAIL %s: got no sample, want req=%b vec=%0d",
                     e.name, e.req, e.vec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
